// File: rtl/sram_model_pkg.sv
// -----------------------------------------------------------------------------
// sram_model_pkg
// Shared types and helpers for the behavioural SRAM models.
//   sram_mode_e        : combined write-through / output-register mode
//   COLL_CNT_W         : width of the saturating collision counter
//   mode_from_params   : folds the two mode parameters into sram_mode_e
//   mode_write_through : true when a port-0 write drives dout0
//   mode_out_reg       : true when the extra output stage is present
//   merge_word         : masked merge of an old and a new word
// -----------------------------------------------------------------------------
package sram_model_pkg;

   typedef enum logic [1:0] {
      MODE_FLOW    = 2'd0,   // 1-cycle read, writes silent on dout0
      MODE_FLOW_WT = 2'd1,   // 1-cycle read, writes echoed on dout0
      MODE_PIPE    = 2'd2,   // 2-cycle read, writes silent on dout0
      MODE_PIPE_WT = 2'd3    // 2-cycle read, writes echoed on dout0
   } sram_mode_e;

   localparam int COLL_CNT_W = 16;

   // merge_word works on a fixed maximum width; callers zero-extend and
   // truncate with casts so one function serves every DATA_WIDTH.
   localparam int MERGE_MAX_W   = 1024;
   localparam int MERGE_IDX_W   = 10;

   function automatic sram_mode_e mode_from_params(input bit write_through, input bit out_reg);
      logic [1:0] sel;
      sel = {out_reg, write_through};
      case (sel)
         2'b00:   return MODE_FLOW;
         2'b01:   return MODE_FLOW_WT;
         2'b10:   return MODE_PIPE;
         2'b11:   return MODE_PIPE_WT;
         default: return MODE_FLOW;
      endcase
   endfunction

   function automatic bit mode_write_through(input sram_mode_e mode);
      case (mode)
         MODE_FLOW_WT, MODE_PIPE_WT: return 1'b1;
         MODE_FLOW, MODE_PIPE:       return 1'b0;
         default:                    return 1'b0;
      endcase
   endfunction

   function automatic bit mode_out_reg(input sram_mode_e mode);
      case (mode)
         MODE_PIPE, MODE_PIPE_WT: return 1'b1;
         MODE_FLOW, MODE_FLOW_WT: return 1'b0;
         default:                 return 1'b0;
      endcase
   endfunction

   // Bit i belongs to group i/grp_w; it takes new_word only when that
   // group's mask bit is set.
   function automatic logic [MERGE_MAX_W-1:0] merge_word(
      input logic [MERGE_MAX_W-1:0] old_word,
      input logic [MERGE_MAX_W-1:0] new_word,
      input logic [MERGE_MAX_W-1:0] mask,
      input int                     grp_w
   );
      logic [MERGE_MAX_W-1:0] res;
      logic [MERGE_IDX_W-1:0] grp;
      for (int i = 0; i < MERGE_MAX_W; i++) begin
         grp    = MERGE_IDX_W'(i / grp_w);
         res[i] = mask[grp] ? new_word[i] : old_word[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// -----------------------------------------------------------------------------
// sram_read_pipe
// Output stage of one SRAM port. Holds dout between reads, produces a
// one-cycle dvalid per read and carries side-band flags with the same
// latency as the data. OUT_REG=1 inserts one extra register stage.
//   clk, rst  : clock, asynchronous active-high reset
//   rd_vld    : a read (or write-through) was accepted this edge
//   rd_data   : word to present on dout
//   rd_flag   : side-band flags aligned with the data
//   dvalid    : dout updated this cycle
//   dout      : held output word
//   flag      : side-band flags, one-cycle pulses
// -----------------------------------------------------------------------------
module sram_read_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int FLAG_W     = 1,
   parameter bit OUT_REG    = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_vld,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic [FLAG_W-1:0]     rd_flag,
   output logic                  dvalid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [FLAG_W-1:0]     flag
);

   logic                  src_vld_s;
   logic [DATA_WIDTH-1:0] src_data_s;
   logic [FLAG_W-1:0]     src_flag_s;

   logic                  dvalid_r;
   logic [DATA_WIDTH-1:0] dout_r;
   logic [FLAG_W-1:0]     flag_r;

   generate
      if (OUT_REG) begin : g_stage
         logic                  vld_r;
         logic [DATA_WIDTH-1:0] data_r;
         logic [FLAG_W-1:0]     flg_r;

         // Extra stage; reset clears it so an in-flight read is discarded
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_r  <= 1'b0;
               data_r <= {DATA_WIDTH{1'b0}};
               flg_r  <= {FLAG_W{1'b0}};
            end else begin
               vld_r  <= rd_vld;
               data_r <= rd_data;
               flg_r  <= rd_flag;
            end
         end

         assign src_vld_s  = vld_r;
         assign src_data_s = data_r;
         assign src_flag_s = flg_r;
      end else begin : g_bypass
         assign src_vld_s  = rd_vld;
         assign src_data_s = rd_data;
         assign src_flag_s = rd_flag;
      end
   endgenerate

   // Output register; dout only moves when a valid word arrives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvalid_r <= 1'b0;
         dout_r   <= {DATA_WIDTH{1'b0}};
         flag_r   <= {FLAG_W{1'b0}};
      end else begin
         dvalid_r <= src_vld_s;
         flag_r   <= src_flag_s;
         if (src_vld_s) begin
            dout_r <= src_data_s;
         end
      end
   end

   assign dvalid = dvalid_r;
   assign dout   = dout_r;
   assign flag   = flag_r;

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// -----------------------------------------------------------------------------
// sram_1rw1r_wmask
// Behavioural simulation model of a 1RW + 1R SRAM macro with per-group
// write mask, optional write-through on port 0, optional output register,
// same-address collision detection and out-of-range address detection.
//   clk0, rst0          : clock, asynchronous active-high reset
//   csb0, web0, wmask0  : port 0 select (low), write enable (low), group mask
//   addr0, din0, dout0  : port 0 address, write data, read data
//   dvalid0             : dout0 updated this cycle
//   csb1, addr1, dout1  : port 1 select (low), address, read data
//   dvalid1             : dout1 updated this cycle
//   collision           : port-1 read hit a port-0 write at the same edge
//   collision_count     : saturating count of collisions
//   addr_err            : an accepted access addressed a missing word
// -----------------------------------------------------------------------------
module sram_1rw1r_wmask
   import sram_model_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 11,
   parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
   parameter int WMASK_WIDTH   = 4,
   parameter int WRITE_THROUGH = 0,
   parameter int OUT_REG       = 0,
   parameter int VERBOSE       = 1
) (
   input  logic                   clk0,
   input  logic                   rst0,
   input  logic                   csb0,
   input  logic                   web0,
   input  logic [WMASK_WIDTH-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0]  din0,
   output logic [DATA_WIDTH-1:0]  dout0,
   output logic                   dvalid0,
   input  logic                   csb1,
   input  logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  dout1,
   output logic                   dvalid1,
   output logic                   collision,
   output logic [COLL_CNT_W-1:0]  collision_count,
   output logic                   addr_err
);

   localparam sram_mode_e          MODE      = mode_from_params(WRITE_THROUGH != 0, OUT_REG != 0);
   localparam bit                  WT_EN     = mode_write_through(MODE);
   localparam bit                  PIPE_EN   = mode_out_reg(MODE);
   localparam int                  GRP_W     = DATA_WIDTH / WMASK_WIDTH;
   localparam int                  MEM_WORDS = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

   // The array spans the full address space so any address indexes it
   // cleanly; words at or above RAM_DEPTH are never written or returned.
   logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

   logic                  acc0_s;
   logic                  acc1_s;
   logic                  ok0_s;
   logic                  ok1_s;
   logic                  wr_en_s;
   logic                  coll_s;
   logic                  err_any_s;
   logic                  vld0_s;
   logic [DATA_WIDTH-1:0] rd0_word_s;
   logic [DATA_WIDTH-1:0] rd1_word_s;
   logic [DATA_WIDTH-1:0] merged_s;
   logic [DATA_WIDTH-1:0] data0_s;
   logic [DATA_WIDTH-1:0] data1_s;
   logic                  coll_out_s;
   logic [COLL_CNT_W-1:0] coll_cnt_r;

   // Access decode, masked merge and per-port read data selection
   always_comb begin
      // Gating with rst0 makes an edge seen during reset accept nothing.
      acc0_s     = !rst0 && !csb0;
      acc1_s     = !rst0 && !csb1;
      ok0_s      = ({1'b0, addr0} < DEPTH_L);
      ok1_s      = ({1'b0, addr1} < DEPTH_L);
      rd0_word_s = mem_r[addr0];
      rd1_word_s = mem_r[addr1];
      merged_s   = DATA_WIDTH'(merge_word(MERGE_MAX_W'(rd0_word_s), MERGE_MAX_W'(din0),
                                          MERGE_MAX_W'(wmask0), GRP_W));
      wr_en_s    = acc0_s && !web0 && ok0_s && (wmask0 != {WMASK_WIDTH{1'b0}});
      coll_s     = acc1_s && wr_en_s && (addr1 == addr0);
      err_any_s  = (acc0_s && !ok0_s) || (acc1_s && !ok1_s);
      vld0_s     = acc0_s && (web0 || WT_EN);

      if (!ok0_s) begin
         data0_s = {DATA_WIDTH{1'b0}};
      end else if (web0) begin
         data0_s = rd0_word_s;
      end else begin
         data0_s = merged_s;
      end

      // A colliding read has no defined value.
      if (coll_s) begin
         data1_s = {DATA_WIDTH{1'bx}};
      end else if (!ok1_s) begin
         data1_s = {DATA_WIDTH{1'b0}};
      end else begin
         data1_s = rd1_word_s;
      end
   end

   // Memory array write; contents are intentionally kept across reset
   always_ff @(posedge clk0) begin
      if (wr_en_s) begin
         mem_r[addr0] <= merged_s;
      end
   end

   // Port 0 output stage also carries the combined address-error flag
   sram_read_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .FLAG_W     (1),
      .OUT_REG    (PIPE_EN)
   ) u_pipe0 (
      .clk     (clk0),
      .rst     (rst0),
      .rd_vld  (vld0_s),
      .rd_data (data0_s),
      .rd_flag (err_any_s),
      .dvalid  (dvalid0),
      .dout    (dout0),
      .flag    (addr_err)
   );

   // Port 1 output stage carries the collision flag aligned with dvalid1
   sram_read_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .FLAG_W     (1),
      .OUT_REG    (PIPE_EN)
   ) u_pipe1 (
      .clk     (clk0),
      .rst     (rst0),
      .rd_vld  (acc1_s),
      .rd_data (data1_s),
      .rd_flag (coll_s),
      .dvalid  (dvalid1),
      .dout    (dout1),
      .flag    (coll_out_s)
   );

   // Saturating collision counter, advanced by the aligned collision pulse
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         coll_cnt_r <= {COLL_CNT_W{1'b0}};
      end else if (coll_out_s && (coll_cnt_r != {COLL_CNT_W{1'b1}})) begin
         coll_cnt_r <= coll_cnt_r + COLL_CNT_W'(1);
      end
   end

   assign collision       = coll_out_s;
   assign collision_count = coll_cnt_r;

   // Simulation messages: anomalies always, access trace when VERBOSE
   always_ff @(posedge clk0) begin
      if (coll_s) begin
         $warning("%m t=%0t collision: port-1 read and port-0 write at addr 0x%0h", $time, addr1);
      end
      if (acc0_s && !ok0_s) begin
         $warning("%m t=%0t port-0 address 0x%0h out of range", $time, addr0);
      end
      if (acc1_s && !ok1_s) begin
         $warning("%m t=%0t port-1 address 0x%0h out of range", $time, addr1);
      end
      if (VERBOSE != 0) begin
         if (acc0_s) begin
            $info("%m t=%0t port-0 %s addr 0x%0h", $time, web0 ? "read" : "write", addr0);
         end
         if (acc1_s) begin
            $info("%m t=%0t port-1 read addr 0x%0h", $time, addr1);
         end
      end
   end

endmodule
